decode_arbiter: RTL and testbench
=================================

DECODE_ARBITER -- requirements
Module: decode_arbiter

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- REQ-003: en_n  input  1  active-low grant enable; high blocks new grants, pending output still drains.
- REQ-004: req  input  4  per-requester request; bit i from requester i.
- REQ-005: mode  input  8  per-requester decode mode, 2 bits each, requester i at [2i+1:2i].
- REQ-006: idx  input  16  per-requester decode index, 4 bits each, requester i at [4i+3:4i].
- REQ-007: gnt  output  4  one-hot grant pulse, at most one bit high per cycle.
- REQ-008: out_valid  output  1  out_y/out_owner hold a decoded result.
- REQ-009: out_ready  input  1  downstream accepts result when high with out_valid.
- REQ-010: out_y  output  16  registered one-hot (or zero) decode result.
- REQ-011: out_owner  output  2  index of requester that produced out_y.

Function
- REQ-012: Block SHALL share one mode-selectable decoder among 4 requesters with round-robin arbitration.
- REQ-013: Capture slot exists in a cycle when en_n=0 and (out_valid=0 or out_ready=1).
- REQ-014: In a capture-slot cycle with req!=0, block SHALL assert gnt[w] combinationally for that cycle only, w = first set req bit searching ptr, ptr+1, ... mod 4.
- REQ-015: No gnt bit SHALL assert outside a capture slot or when req=0.
- REQ-016: Requester i SHALL hold req[i], mode, idx stable until it sees gnt[i]; it may drop or re-raise req the cycle after.
- REQ-017: On the edge ending a grant cycle, block SHALL load out_y=decode(mode_w, idx_w), out_owner=w, out_valid=1; latency grant-to-valid is exactly 1 cycle.
- REQ-018: decode: mode 00 -> bit idx[1:0] set within out_y[3:0]; 01 -> bit idx[2:0] within [7:0]; 10 -> bit idx[3:0] within [15:0]; 11 -> out_y=0, out_valid still 1.
- REQ-019: All out_y bits above the selected range SHALL be 0.
- REQ-020: On grant to w, ptr SHALL become (w+1) mod 4 at the same edge; ptr unchanged otherwise.
- REQ-021: While out_valid=1 and out_ready=0, out_y, out_owner, out_valid SHALL hold stable.
- REQ-022: out_valid=1 and out_ready=1 with no grant in that cycle -> out_valid=0 next cycle.
- REQ-023: out_valid=1, out_ready=1, grant in same cycle -> new result loads next edge, out_valid stays 1 (back-to-back, 1 result/cycle).
- REQ-024: en_n rising while out_valid=1 SHALL NOT drop out_valid; result drains normally.
- REQ-025: States: EMPTY (out_valid=0), FULL (out_valid=1); EMPTY->FULL on grant; FULL->EMPTY on accept without grant; FULL->FULL on stall or accept+grant.

Reset
- REQ-026: rst_n=0 at an edge SHALL set out_valid=0, out_y=0, out_owner=0, ptr=0 (requester 0 highest priority).
- REQ-027: gnt SHALL be 0 in any cycle where rst_n=0, regardless of req.
- REQ-028: Reset mid-operation SHALL discard the held result; no accept handshake required.

Structure
- REQ-029: Shared package decode_arbiter_pkg SHALL hold NUM_REQ=4, mode encodings (MODE_2X4=00, MODE_3X8=01, MODE_4X16=10, MODE_OFF=11), widths of mode/idx/out_y.
- REQ-030: Combinational decode per REQ-018 SHALL be a sub-module mode_decoder (inputs mode, idx; output 16-bit y).
- REQ-031: Arbitration, ptr, and output register SHALL live in decode_arbiter.

Verification
- REQ-032: Reset, req=4'b1111, out_ready=1 continuously -> gnt sequence 0001,0010,0100,1000,0001; out_owner follows one cycle later.
- REQ-033: req[2] only, mode=10, idx=4'hB -> gnt=0100; next cycle out_valid=1, out_y=16'h0800, out_owner=2.
- REQ-034: req[1], mode=00, idx=4'hE -> out_y=16'h0004; mode=11 -> out_y=0, out_valid=1.
- REQ-035: out_valid=1, out_ready=0 for 5 cycles, req=1111 -> no gnt, out_y stable; out_ready=1 -> grant that cycle, new result next cycle.
- REQ-036: en_n=1 with req=1111 -> gnt=0 always; held result drains on out_ready=1, then out_valid=0.
- REQ-037: rst_n=0 while out_valid=1 -> next cycle out_valid=0, out_y=0, following grant goes to requester 0.

Source files
------------

// File: rtl/decode_arbiter_pkg.sv
// Shared types and constants for the round-robin decode arbiter.
// Holds widths, mode encodings and the rotating-priority pick helper.
package decode_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;
    localparam int MODE_W  = 2;
    localparam int IDX_W   = 4;
    localparam int Y_W     = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_2X4  = 2'b00,
        MODE_3X8  = 2'b01,
        MODE_4X16 = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // First set request searching ptr, ptr+1, ... with wrap-around.
    // Walk from the farthest offset down so the nearest match wins.
    function automatic pick_t rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr
    );
        pick_t            p;
        logic [PTR_W-1:0] cand;
        p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + PTR_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mode_decoder.sv
// Shared mode-selectable one-hot decoder (2:4, 3:8, 4:16 or off).
// Bits above the selected range are always zero.
module mode_decoder
    import decode_arbiter_pkg::*;
(
    input  logic [MODE_W-1:0] mode_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [Y_W-1:0]    y_o
);

    // Select decode width from mode; unused index bits are ignored.
    always_comb begin
        y_o = '0;
        unique case (mode_e'(mode_i))
            MODE_2X4:  y_o = {12'h000, 4'b0001 << idx_i[1:0]};
            MODE_3X8:  y_o = {8'h00, 8'b0000_0001 << idx_i[2:0]};
            MODE_4X16: y_o = 16'h0001 << idx_i;
            MODE_OFF:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_arbiter.sv
// Four requesters share one decoder through a round-robin arbiter.
// Result sits in a one-deep valid/ready output register.
module decode_arbiter
    import decode_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*2-1:0]  mode,
    input  logic [NUM_REQ*4-1:0]  idx,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Y_W-1:0]        out_y,
    output logic [PTR_W-1:0]      out_owner
);

    state_e              state_q;
    logic                out_valid_q;
    logic [Y_W-1:0]      out_y_q;
    logic [PTR_W-1:0]    out_owner_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;

    logic                slot;
    logic                grant_any;
    pick_t               pick;
    logic [PTR_W-1:0]    win;
    logic [MODE_W-1:0]   win_mode;
    logic [IDX_W-1:0]    win_idx;
    logic [Y_W-1:0]      dec_y;

    // Capture slot, rotating pick, grant pulse and operand mux.
    always_comb begin
        slot      = rst_n && !en_n && (!out_valid_q || out_ready);
        pick      = rr_pick(req, ptr_q);
        grant_any = slot && pick.found;
        win       = pick.idx;
        gnt       = grant_any ? (4'b0001 << win) : '0;
        win_mode  = mode[{win, 1'b0} +: MODE_W];
        win_idx   = idx[{win, 2'b00} +: IDX_W];
        ptr_d     = grant_any ? win + 2'd1 : ptr_q;
    end

    mode_decoder u_dec (
        .mode_i (win_mode),
        .idx_i  (win_idx),
        .y_o    (dec_y)
    );

    // Output register FSM: load on grant, drain on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_owner_q <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            unique case (state_q)
                ST_EMPTY: begin
                    if (grant_any) begin
                        state_q     <= ST_FULL;
                        out_valid_q <= 1'b1;
                        out_y_q     <= dec_y;
                        out_owner_q <= win;
                    end
                end
                ST_FULL: begin
                    if (grant_any) begin
                        out_y_q     <= dec_y;
                        out_owner_q <= win;
                    end else if (out_ready) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_owner = out_owner_q;

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed-vector bench for decode_arbiter.
// Grant checked mid-cycle, registered outputs just after the edge.
module tb_decode_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_n;
    logic [3:0]  req;
    logic [7:0]  mode;
    logic [15:0] idx;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic [1:0]  out_owner;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        en_n;
        logic [3:0]  req;
        logic [7:0]  mode;
        logic [15:0] idx;
        logic        rdy;
        logic [3:0]  gnt;
        logic        vld;
        logic        chk_y;
        logic [15:0] y;
        logic [1:0]  own;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    decode_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_n      (en_n),
        .req       (req),
        .mode      (mode),
        .idx       (idx),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_owner (out_owner)
    );

    function automatic vec_t mk(
        input logic r, input logic e, input logic [3:0] q,
        input logic [7:0] m, input logic [15:0] x, input logic rd,
        input logic [3:0] g, input logic v, input logic c,
        input logic [15:0] y, input logic [1:0] o
    );
        vec_t t;
        t.rst_n = r; t.en_n = e; t.req = q; t.mode = m;
        t.idx = x; t.rdy = rd; t.gnt = g; t.vld = v;
        t.chk_y = c; t.y = y; t.own = o;
        return t;
    endfunction

    task automatic check(input string nm, input int step,
                         input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int step);
        rst_n     = t.rst_n;
        en_n      = t.en_n;
        req       = t.req;
        mode      = t.mode;
        idx       = t.idx;
        out_ready = t.rdy;
        @(negedge clk);
        check("gnt", step, {12'h0, gnt}, {12'h0, t.gnt});
        @(posedge clk);
        #1;
        check("out_valid", step, {15'h0, out_valid}, {15'h0, t.vld});
        if (t.chk_y) begin
            check("out_y", step, out_y, t.y);
            check("out_owner", step, {14'h0, out_owner}, {14'h0, t.own});
        end
    endtask

    initial begin
        int s;
        s = 0;
        // reset, then full rotation with every requester asking
        tbl.push_back(mk(0,0,4'hF,8'hAA,16'h3210,1, 4'h0,0,1,16'h0000,0));
        tbl.push_back(mk(0,0,4'hF,8'hAA,16'h3210,1, 4'h0,0,1,16'h0000,0));
        tbl.push_back(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h1,1,1,16'h0001,0));
        tbl.push_back(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h2,1,1,16'h0002,1));
        tbl.push_back(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h4,1,1,16'h0004,2));
        tbl.push_back(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h8,1,1,16'h0008,3));
        tbl.push_back(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h1,1,1,16'h0001,0));
        // single requester 2, 4:16 decode of B
        tbl.push_back(mk(1,0,4'h4,8'h20,16'h0B00,1, 4'h4,1,1,16'h0800,2));
        // requester 1, 2:4 decode of E, then mode off
        tbl.push_back(mk(1,0,4'h2,8'h00,16'h00E0,1, 4'h2,1,1,16'h0004,1));
        tbl.push_back(mk(1,0,4'h2,8'h0C,16'h00E0,1, 4'h2,1,1,16'h0000,1));
        // accept with no request drains, then idle
        tbl.push_back(mk(1,0,4'h0,8'h00,16'h0000,1, 4'h0,0,0,16'h0000,0));
        tbl.push_back(mk(1,0,4'h0,8'h00,16'h0000,1, 4'h0,0,0,16'h0000,0));
        // requester 3, 3:8 decode of D (low 3 bits = 5)
        tbl.push_back(mk(1,0,4'h8,8'h40,16'hD000,1, 4'h8,1,1,16'h0020,3));
        // two requesters alternate, high idx bits ignored in 2:4 mode
        tbl.push_back(mk(1,0,4'hA,8'h00,16'h7030,1, 4'h2,1,1,16'h0008,1));
        tbl.push_back(mk(1,0,4'hA,8'h00,16'h7030,1, 4'h8,1,1,16'h0008,3));

        foreach (tbl[i]) begin
            apply(tbl[i], s);
            s++;
        end

        // stall: result held, no grants while downstream not ready
        for (int k = 0; k < 5; k++) begin
            apply(mk(1,0,4'hF,8'hAA,16'h3210,0, 4'h0,1,1,16'h0008,3), s);
            s++;
        end
        apply(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h1,1,1,16'h0001,0), s);
        s++;

        // enable deasserted: held result survives, then drains
        for (int k = 0; k < 3; k++) begin
            apply(mk(1,1,4'hF,8'hAA,16'h3210,0, 4'h0,1,1,16'h0001,0), s);
            s++;
        end
        apply(mk(1,1,4'hF,8'hAA,16'h3210,1, 4'h0,0,0,16'h0000,0), s);
        s++;
        apply(mk(1,1,4'hF,8'hAA,16'h3210,1, 4'h0,0,0,16'h0000,0), s);
        s++;

        // reset mid-operation discards result and restores priority
        apply(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h2,1,1,16'h0002,1), s);
        s++;
        apply(mk(0,0,4'hF,8'hAA,16'h3210,1, 4'h0,0,1,16'h0000,0), s);
        s++;
        apply(mk(1,0,4'hF,8'hAA,16'h3210,1, 4'h1,1,1,16'h0001,0), s);
        s++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
